mult_div_unit: RTL and testbench

Multiply/divide unit for the EX stage of the five-stage pipeline. It sits directly downstream of the ID/EX pipeline register, beside the ALU. It consumes the forwarded rs/rt operands of the EX-stage instruction and runs mult/multu/div/divu over a fixed multi-cycle latency. It owns the HI/LO architectural registers; the EX result mux reads them for mfhi/mflo.

---
 rtl/mdu_pkg.sv | 31 +++
 rtl/mdu_calc.sv | 55 +++++
 rtl/mult_div_unit.sv | 71 +++++++
 tb/tb_mult_div_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared MDU op encodings, default latencies and op decode (also used by the hazard unit).
// MDU_MADD_EN: when defined, op 7 (MADD) decodes as a multi-cycle accumulate.
package mdu_pkg;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_MADD  = 3'd7;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  function automatic logic is_multicycle(input logic [2:0] op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational MDU datapath: (op, A, B, HI, LO) -> next {HI,LO} plus divide-by-zero flag.
// MDU_MADD_EN adds the {HI,LO} + signed product accumulate path for op 7.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [31:0] HI,
  input  logic [31:0] LO,
  output logic [63:0] result,
  output logic        div_zero
);

  logic [63:0] a_sext, b_sext, prod_s, prod_u;
  logic [31:0] mag_a, mag_b, sdiv_b, udiv_b;
  logic [31:0] sq, sr, sq_fix, sr_fix, uq, ur;

  // Sign-extended 64-bit product modulo 2^64 equals the signed 32x32 product.
  assign a_sext = {{32{A[31]}}, A};
  assign b_sext = {{32{B[31]}}, B};
  assign prod_s = a_sext * b_sext;
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide via magnitudes; avoids the INT_MIN / -1 overflow corner entirely.
  assign mag_a  = A[31] ? (32'd0 - A) : A;
  assign mag_b  = B[31] ? (32'd0 - B) : B;
  assign sdiv_b = (B == 32'd0) ? 32'd1 : mag_b;
  assign udiv_b = (B == 32'd0) ? 32'd1 : B;
  assign sq     = mag_a / sdiv_b;
  assign sr     = mag_a % sdiv_b;
  assign sq_fix = (A[31] ^ B[31]) ? (32'd0 - sq) : sq;
  assign sr_fix = A[31] ? (32'd0 - sr) : sr;
  assign uq     = A / udiv_b;
  assign ur     = A % udiv_b;

  assign div_zero = is_div(op) && (B == 32'd0);

  always_comb begin
    result = {HI, LO};
    case (op)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV:   result = {sr_fix, sq_fix};
      OP_DIVU:  result = {ur, uq};
      OP_MTHI:  result = {A, LO};
      OP_MTLO:  result = {HI, A};
`ifdef MDU_MADD_EN
      OP_MADD:  result = {HI, LO} + prod_s;
`endif
      default:  result = {HI, LO};
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit owning HI/LO; multi-cycle ops hold busy for MULT/DIV_CYCLES, MTHI/MTLO take 1 cycle.
// No backpressure beyond start/busy: start while busy is ignored. MDU_MADD_EN enables op 7 (MADD).
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic [CNT_W-1:0] cnt, lat;
  logic [31:0]      res_hi, res_lo;
  logic [63:0]      calc_res;
  logic             calc_div_zero;
  logic             accept;

  mdu_calc u_calc (
    .op       (op),
    .A        (A),
    .B        (B),
    .HI       (HI),
    .LO       (LO),
    .result   (calc_res),
    .div_zero (calc_div_zero)
  );

  assign accept    = start && !busy;
  assign stall_req = busy || (start && is_multicycle(op));
  assign lat       = is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      cnt    <= '0;
      res_hi <= 32'd0;
      res_lo <= 32'd0;
      HI     <= 32'd0;
      LO     <= 32'd0;
    end else if (accept && is_multicycle(op)) begin
      // Divide by zero still runs the full latency but commits the current HI/LO.
      {res_hi, res_lo} <= calc_div_zero ? {HI, LO} : calc_res;
      cnt              <= lat;
      busy             <= 1'b1;
    end else if (accept && ((op == OP_MTHI) || (op == OP_MTLO))) begin
      {HI, LO} <= calc_res;
    end else if (busy) begin
      if (cnt == CNT_W'(1)) begin
        HI   <= res_hi;
        LO   <= res_lo;
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboarded bench for mult_div_unit: directed vectors, expected {HI,LO,busy length} queued at issue.
// A negedge monitor pops and compares whenever busy falls.
module tb_mult_div_unit;
  import mdu_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy, stall_req;
  logic [31:0] HI, LO;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   abort_pending = 0;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .stall_req (stall_req),
    .HI        (HI),
    .LO        (LO)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: counts busy cycles and compares on each completion.
  initial begin
    int  len = 0;
    bit  prev_busy = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        len++;
      end else if (prev_busy) begin
        if (abort_pending) begin
          abort_pending = 0;
        end else if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_completion: HI=0x%08h LO=0x%08h with empty queue", HI, LO);
        end else begin
          e = exp_q.pop_front();
          check32("done_hi", HI, e.hi);
          check32("done_lo", LO, e.lo);
          check32("busy_len", len, e.cycles);
        end
        len = 0;
      end
      prev_busy = (busy === 1'b1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] ehi, input logic [31:0] elo,
                       input int cyc);
    exp_t e;
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    #1;
    check32("stall_req_issue", {31'd0, stall_req}, 32'd1);
    if (push) begin
      e.hi = ehi; e.lo = elo; e.cycles = cyc;
      exp_q.push_back(e);
    end
    tick();
    start = 1'b0;
    op    = OP_NONE;
    A     = $urandom;
    B     = $urandom;
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] a);
    start = 1'b1;
    op    = o;
    A     = a;
    tick();
    start = 1'b0;
    op    = OP_NONE;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy === 1'b0) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL busy_timeout: busy=%b after 100 cycles, expected 0", busy);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = OP_NONE;
    A     = 32'd0;
    B     = 32'd0;
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk);
    check32("reset_busy", {31'd0, busy}, 32'd0);
    check32("reset_stall", {31'd0, stall_req}, 32'd0);
    check32("reset_hi", HI, 32'h0);
    check32("reset_lo", LO, 32'h0);

    // Back-to-back multi-cycle ops.
    issue(OP_MULT,  32'hFFFF_FFFE, 32'd3, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    check32("stall_while_busy", {31'd0, stall_req}, 32'd1);
    wait_idle();
    issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 1, 32'h0000_0002, 32'hFFFF_FFFA, 5);
    wait_idle();
    issue(OP_DIV,   32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    wait_idle();
    issue(OP_DIVU,  32'd7,         32'd2, 1, 32'd1,         32'd3,         10);
    wait_idle();

    // Divide by zero leaves HI/LO alone.
    @(posedge clk); #1;
    mt(OP_MTHI, 32'h11);
    check32("mthi_hi", HI, 32'h11);
    mt(OP_MTLO, 32'h22);
    check32("mtlo_lo", LO, 32'h22);
    check32("mtlo_hi_kept", HI, 32'h11);
    issue(OP_DIV, 32'd100, 32'd0, 1, 32'h11, 32'h22, 10);
    wait_idle();
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0, 32'h8000_0000, 10);
    wait_idle();

    // MTHI while busy is ignored.
    issue(OP_MULT, 32'd7, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 5);
    tick();
    mt(OP_MTHI, 32'h1234);
    check32("mthi_ignored_hi", HI, 32'h0);
    check32("mthi_ignored_busy", {31'd0, busy}, 32'd1);
    wait_idle();
    mt(OP_MTLO, 32'h55);
    check32("mtlo_after_done", LO, 32'h55);
    check32("mtlo_after_done_hi", HI, 32'hFFFF_FFFF);

    // Reset during the third cycle of a divide discards it.
    abort_pending = 1;
    issue(OP_DIV, 32'd100, 32'd7, 0, 32'd0, 32'd0, 0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check32("midreset_busy", {31'd0, busy}, 32'd0);
    check32("midreset_hi", HI, 32'h0);
    check32("midreset_lo", LO, 32'h0);
    repeat (15) @(negedge clk);
    check32("midreset_late_hi", HI, 32'h0);
    check32("midreset_late_lo", LO, 32'h0);
    check32("midreset_late_busy", {31'd0, busy}, 32'd0);

    // MADD accumulate, or a no-op when the feature is compiled out.
    @(posedge clk); #1;
    mt(OP_MTHI, 32'h0);
    mt(OP_MTLO, 32'h5);
`ifdef MDU_MADD_EN
    issue(OP_MADD, 32'd2, 32'd3, 1, 32'h0, 32'd11, 5);
    wait_idle();
`else
    start = 1'b1;
    op    = OP_MADD;
    A     = 32'd2;
    B     = 32'd3;
    #1;
    check32("madd_off_stall", {31'd0, stall_req}, 32'd0);
    tick();
    start = 1'b0;
    op    = OP_NONE;
    check32("madd_off_busy", {31'd0, busy}, 32'd0);
    repeat (6) @(negedge clk);
    check32("madd_off_hi", HI, 32'h0);
    check32("madd_off_lo", LO, 32'h5);
`endif

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check32("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
